// File: rtl/xcvr_reconfig_sequencer.sv
// -----------------------------------------------------------------------------
// xcvr_reconfig_sequencer
//
// Purpose:
//   Avalon-MM master for the transceiver reconfiguration management port
//   (7-bit address, 32-bit data, waitrequest). The port is shared between
//   NREQ requesters, such as the host CSR block and the link-tune logic, by
//   round-robin arbitration.
//   Each PMA analog read or write request becomes a fixed indirect register
//   sequence:
//     1. write the logical channel
//     2. write the PMA offset
//     3. write the data (writes only)
//     4. write the control/command register
//     5. poll the busy flag
//     6. read back the data register (reads only)
//   Exactly one response is returned per request.
//
// Ports:
//   mgmt_clk_clk               single clock
//   mgmt_rst_reset             synchronous active-high reset
//   req_valid[NREQ]            request pending; held until req_ready
//   req_ready[NREQ]            one-hot grant, combinational in IDLE;
//                              request fields are latched on this cycle
//   req_write[NREQ]            1 = PMA write, 0 = PMA read
//   req_chan[NREQ*CH_W]        logical channel, requester i at [i*CH_W +: CH_W]
//   req_offset[NREQ*6]         PMA analog offset
//   req_wdata[NREQ*16]         write value
//   rsp_valid[NREQ]            one-hot, one-cycle response pulse
//   rsp_rdata[16]              read value (0 for writes and errored ops)
//   rsp_error                  status error bit or poll timeout
//   reconfig_mgmt_*            Avalon-MM master; all outputs registered
//   busy                       sequencer is not idle
// -----------------------------------------------------------------------------
module xcvr_reconfig_sequencer #(
  parameter int         NREQ          = 2,
  parameter int         CH_W          = 10,
  parameter int         TIMEOUT_POLLS = 1023,
  parameter logic [6:0] A_CH          = 7'h08,
  parameter logic [6:0] A_CTRL        = 7'h0A,
  parameter logic [6:0] A_OFS         = 7'h0B,
  parameter logic [6:0] A_DATA        = 7'h0C
) (
  input  logic                 mgmt_clk_clk,
  input  logic                 mgmt_rst_reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*CH_W-1:0] req_chan,
  input  logic [NREQ*6-1:0]    req_offset,
  input  logic [NREQ*16-1:0]   req_wdata,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [15:0]          rsp_rdata,
  output logic                 rsp_error,
  output logic [6:0]           reconfig_mgmt_address,
  output logic                 reconfig_mgmt_read,
  output logic                 reconfig_mgmt_write,
  output logic [31:0]          reconfig_mgmt_writedata,
  input  logic [31:0]          reconfig_mgmt_readdata,
  input  logic                 reconfig_mgmt_waitrequest,
  output logic                 busy
);

  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PCNT_W = $clog2(TIMEOUT_POLLS + 1);
  // Poll count value at which a further busy read means timeout.
  localparam logic [PCNT_W-1:0] POLL_LAST = PCNT_W'(TIMEOUT_POLLS - 1);

  // Status bits in the control register.
  localparam int ST_BUSY = 8;
  localparam int ST_ERR  = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_CH,
    S_WR_OFS,
    S_WR_DATA,
    S_WR_CTRL,
    S_POLL,
    S_RD_DATA,
    S_RESP
  } state_t;

  state_t              state_reg;
  logic [IDX_W-1:0]    ptr_reg;
  logic [IDX_W-1:0]    gnt_reg;
  logic                wr_op_reg;
  logic [5:0]          ofs_reg;
  logic [15:0]         wdata_reg;
  logic                err_reg;
  logic [PCNT_W-1:0]   poll_cnt_reg;

  logic [6:0]          address_reg;
  logic                read_reg;
  logic                write_reg;
  logic [31:0]         writedata_reg;
  logic [NREQ-1:0]     rsp_valid_reg;
  logic [15:0]         rsp_rdata_reg;
  logic                rsp_error_reg;

  // ---------------------------------------------------------------------------
  // Per-requester field slices
  // ---------------------------------------------------------------------------
  logic [CH_W-1:0] chan_arr  [NREQ];
  logic [5:0]      ofs_arr   [NREQ];
  logic [15:0]     wdata_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_fields
      assign chan_arr[gi]  = req_chan[gi*CH_W +: CH_W];
      assign ofs_arr[gi]   = req_offset[gi*6 +: 6];
      assign wdata_arr[gi] = req_wdata[gi*16 +: 16];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin arbiter
  //
  // req_upper holds the requests at or after the pointer. If any exist, the
  // lowest of them wins. Otherwise the search wraps to the lowest valid
  // request overall.
  // ---------------------------------------------------------------------------
  logic [NREQ-1:0]  req_upper;
  logic             grant_any;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] ptr_next;
  logic [NREQ-1:0]  grant_onehot;
  logic             grant_fire;

  always_comb begin
    req_upper = req_valid & ~((NREQ'(1) << ptr_reg) - NREQ'(1));
    grant_any = |req_valid;
    grant_idx = '0;
    if (|req_upper) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (req_upper[k]) begin
          grant_idx = IDX_W'(k);
        end
      end
    end else begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (req_valid[k]) begin
          grant_idx = IDX_W'(k);
        end
      end
    end
  end

  assign ptr_next = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  assign grant_onehot = NREQ'(1) << grant_idx;

  // Suppress the grant while reset is held. Otherwise a requester could
  // see req_ready and drop its request while the FSM is being cleared.
  assign grant_fire = (state_reg == S_IDLE) && grant_any && !mgmt_rst_reset;
  assign req_ready  = grant_fire ? grant_onehot : '0;

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  //
  // The Avalon outputs are loaded on the same edge as the state transition.
  // The access for a state is therefore presented on the first cycle of
  // that state. The outputs hold until a cycle where waitrequest is low.
  // ---------------------------------------------------------------------------
  logic access_done;
  assign access_done = !reconfig_mgmt_waitrequest;

  always_ff @(posedge mgmt_clk_clk) begin
    if (mgmt_rst_reset) begin
      state_reg     <= S_IDLE;
      ptr_reg       <= '0;
      gnt_reg       <= '0;
      wr_op_reg     <= 1'b0;
      ofs_reg       <= '0;
      wdata_reg     <= '0;
      err_reg       <= 1'b0;
      poll_cnt_reg  <= '0;
      address_reg   <= '0;
      read_reg      <= 1'b0;
      write_reg     <= 1'b0;
      writedata_reg <= '0;
      rsp_valid_reg <= '0;
      rsp_rdata_reg <= '0;
      rsp_error_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          poll_cnt_reg <= '0;
          if (grant_any) begin
            gnt_reg       <= grant_idx;
            ptr_reg       <= ptr_next;
            wr_op_reg     <= req_write[grant_idx];
            ofs_reg       <= ofs_arr[grant_idx];
            wdata_reg     <= wdata_arr[grant_idx];
            err_reg       <= 1'b0;
            address_reg   <= A_CH;
            write_reg     <= 1'b1;
            writedata_reg <= 32'(chan_arr[grant_idx]);
            state_reg     <= S_WR_CH;
          end
        end

        S_WR_CH: begin
          if (access_done) begin
            address_reg   <= A_OFS;
            writedata_reg <= {26'b0, ofs_reg};
            state_reg     <= S_WR_OFS;
          end
        end

        S_WR_OFS: begin
          if (access_done) begin
            if (wr_op_reg) begin
              address_reg   <= A_DATA;
              writedata_reg <= {16'b0, wdata_reg};
              state_reg     <= S_WR_DATA;
            end else begin
              address_reg   <= A_CTRL;
              writedata_reg <= 32'h2;
              state_reg     <= S_WR_CTRL;
            end
          end
        end

        S_WR_DATA: begin
          if (access_done) begin
            address_reg   <= A_CTRL;
            writedata_reg <= 32'h1;
            state_reg     <= S_WR_CTRL;
          end
        end

        S_WR_CTRL: begin
          if (access_done) begin
            address_reg   <= A_CTRL;
            write_reg     <= 1'b0;
            read_reg      <= 1'b1;
            writedata_reg <= '0;
            state_reg     <= S_POLL;
          end
        end

        // read_reg stays high across back-to-back polls. Every completed
        // read counts toward the timeout.
        S_POLL: begin
          if (access_done) begin
            poll_cnt_reg <= poll_cnt_reg + 1'b1;
            if (!reconfig_mgmt_readdata[ST_BUSY]) begin
              if (wr_op_reg) begin
                address_reg   <= '0;
                read_reg      <= 1'b0;
                rsp_valid_reg <= NREQ'(1) << gnt_reg;
                rsp_rdata_reg <= '0;
                rsp_error_reg <= reconfig_mgmt_readdata[ST_ERR];
                state_reg     <= S_RESP;
              end else begin
                err_reg     <= reconfig_mgmt_readdata[ST_ERR];
                address_reg <= A_DATA;
                state_reg   <= S_RD_DATA;
              end
            end else if (poll_cnt_reg == POLL_LAST) begin
              // The engine never went idle, so the data register cannot
              // be trusted. Skip the readback.
              address_reg   <= '0;
              read_reg      <= 1'b0;
              rsp_valid_reg <= NREQ'(1) << gnt_reg;
              rsp_rdata_reg <= '0;
              rsp_error_reg <= 1'b1;
              state_reg     <= S_RESP;
            end
          end
        end

        S_RD_DATA: begin
          if (access_done) begin
            address_reg   <= '0;
            read_reg      <= 1'b0;
            rsp_valid_reg <= NREQ'(1) << gnt_reg;
            rsp_rdata_reg <= err_reg ? 16'h0 : reconfig_mgmt_readdata[15:0];
            rsp_error_reg <= err_reg;
            state_reg     <= S_RESP;
          end
        end

        S_RESP: begin
          rsp_valid_reg <= '0;
          rsp_rdata_reg <= '0;
          rsp_error_reg <= 1'b0;
          state_reg     <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Only the low half of readdata carries PMA data and status.
  logic unused_readdata_hi;
  assign unused_readdata_hi = ^reconfig_mgmt_readdata[31:16];

  assign reconfig_mgmt_address   = address_reg;
  assign reconfig_mgmt_read      = read_reg;
  assign reconfig_mgmt_write     = write_reg;
  assign reconfig_mgmt_writedata = writedata_reg;
  assign rsp_valid               = rsp_valid_reg;
  assign rsp_rdata               = rsp_rdata_reg;
  assign rsp_error               = rsp_error_reg;
  assign busy                    = (state_reg != S_IDLE);

endmodule

// File: tb/tb_xcvr_reconfig_sequencer.sv
module tb_xcvr_reconfig_sequencer;

  localparam int         NREQ   = 2;
  localparam int         CH_W   = 10;
  localparam int         TOUT   = 4;
  localparam logic [6:0] A_CH   = 7'h08;
  localparam logic [6:0] A_CTRL = 7'h0A;
  localparam logic [6:0] A_OFS  = 7'h0B;
  localparam logic [6:0] A_DATA = 7'h0C;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_write;
  logic [NREQ*CH_W-1:0] req_chan;
  logic [NREQ*6-1:0]    req_offset;
  logic [NREQ*16-1:0]   req_wdata;
  logic [NREQ-1:0]      rsp_valid;
  logic [15:0]          rsp_rdata;
  logic                 rsp_error;
  logic [6:0]           address;
  logic                 read;
  logic                 write;
  logic [31:0]          writedata;
  logic [31:0]          readdata;
  logic                 waitrequest;
  logic                 busy;

  always #5 clk = ~clk;

  xcvr_reconfig_sequencer #(
    .NREQ(NREQ), .CH_W(CH_W), .TIMEOUT_POLLS(TOUT),
    .A_CH(A_CH), .A_CTRL(A_CTRL), .A_OFS(A_OFS), .A_DATA(A_DATA)
  ) dut (
    .mgmt_clk_clk              (clk),
    .mgmt_rst_reset            (rst),
    .req_valid                 (req_valid),
    .req_ready                 (req_ready),
    .req_write                 (req_write),
    .req_chan                  (req_chan),
    .req_offset                (req_offset),
    .req_wdata                 (req_wdata),
    .rsp_valid                 (rsp_valid),
    .rsp_rdata                 (rsp_rdata),
    .rsp_error                 (rsp_error),
    .reconfig_mgmt_address     (address),
    .reconfig_mgmt_read        (read),
    .reconfig_mgmt_write       (write),
    .reconfig_mgmt_writedata   (writedata),
    .reconfig_mgmt_readdata    (readdata),
    .reconfig_mgmt_waitrequest (waitrequest),
    .busy                      (busy)
  );

  typedef struct {
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] data;
  } acc_t;

  typedef struct {
    logic [1:0]  onehot;
    logic [15:0] rdata;
    logic        err;
    int          lat;
  } rsp_t;

  acc_t exp_acc[$];
  rsp_t exp_rsp[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int grant_cyc = 0;
  int ctrl_reads = 0;
  int ctrl_base = 0;
  int busy_polls = 0;
  int wait_cycles = 0;
  int wait_base = 0;
  int wait_len = 0;
  logic [6:0]  wait_addr = 7'h0;
  logic [31:0] status_val = 32'h0;
  logic [31:0] data_val = 32'h0;
  bit          acc_chk_en = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- Avalon slave model ----------------
  always_comb begin
    readdata = 32'h0;
    if (address == A_CTRL)
      readdata = ((ctrl_reads - ctrl_base) < busy_polls) ? 32'h100 : status_val;
    else if (address == A_DATA)
      readdata = data_val;
  end

  always_comb
    waitrequest = (read || write) && (address == wait_addr) &&
                  ((wait_cycles - wait_base) < wait_len);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (read && !waitrequest && address == A_CTRL) ctrl_reads <= ctrl_reads + 1;
    if (waitrequest) wait_cycles <= wait_cycles + 1;
  end

  // ---------------- Monitor / scoreboard ----------------
  bit          prev_wait = 1'b0;
  logic [6:0]  prev_addr;
  logic [31:0] prev_wd;
  logic        prev_rd, prev_wr;

  always @(negedge clk) begin
    if (|req_ready) begin
      grant_cyc = cyc;
      if (exp_rsp.size() == 0) chk("unexpected_grant", 32'(req_ready), 32'h0);
      else chk("grant", 32'(req_ready), 32'(exp_rsp[0].onehot));
    end
    if (|rsp_valid) begin
      if (exp_rsp.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
      end else begin
        rsp_t e;
        e = exp_rsp.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(e.onehot));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
        chk("rsp_error", 32'(rsp_error), 32'(e.err));
        chk("rsp_latency", 32'(cyc - grant_cyc), 32'(e.lat));
        $display("rsp valid=%b rdata=0x%04h err=%b latency=%0d", rsp_valid, rsp_rdata,
                 rsp_error, cyc - grant_cyc);
      end
    end
    if (prev_wait && (read || write)) begin
      chk("wait_stable_addr", 32'(address), 32'(prev_addr));
      chk("wait_stable_wdata", writedata, prev_wd);
      chk("wait_stable_rw", 32'({read, write}), 32'({prev_rd, prev_wr}));
    end
    prev_wait = (read || write) && waitrequest;
    prev_addr = address;
    prev_wd   = writedata;
    prev_rd   = read;
    prev_wr   = write;
    if (acc_chk_en && (read || write) && !waitrequest) begin
      if (exp_acc.size() == 0) begin
        chk("unexpected_access", 32'(address), 32'h7F);
      end else begin
        acc_t a;
        a = exp_acc.pop_front();
        chk("acc_write", 32'(write), 32'(a.wr));
        chk("acc_read", 32'(read), 32'(!a.wr));
        chk("acc_addr", 32'(address), 32'(a.addr));
        chk("acc_wdata", writedata, a.data);
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic push_acc(input logic wr, input logic [6:0] addr, input logic [31:0] data);
    acc_t a;
    a.wr = wr; a.addr = addr; a.data = data;
    exp_acc.push_back(a);
  endtask

  // Expected access list and response for one request.
  // polls: total completed status reads. timeout: busy never cleared.
  // st_err: status error bit set. extra: waitrequest cycles inserted.
  task automatic exp_req(input int idx, input bit wr, input logic [9:0] ch,
                         input logic [5:0] ofs, input logic [15:0] wd,
                         input int polls, input bit timeout, input bit st_err,
                         input logic [15:0] rd, input int extra);
    rsp_t r;
    push_acc(1'b1, A_CH, {22'b0, ch});
    push_acc(1'b1, A_OFS, {26'b0, ofs});
    if (wr) push_acc(1'b1, A_DATA, {16'b0, wd});
    push_acc(1'b1, A_CTRL, wr ? 32'h1 : 32'h2);
    for (int i = 0; i < polls; i++) push_acc(1'b0, A_CTRL, 32'h0);
    if (!wr && !timeout) push_acc(1'b0, A_DATA, 32'h0);
    r.onehot = (idx == 0) ? 2'b01 : 2'b10;
    r.rdata  = (wr || timeout || st_err) ? 16'h0 : rd;
    r.err    = timeout || st_err;
    r.lat    = 6 + (polls - 1) + extra - ((timeout && !wr) ? 1 : 0);
    exp_rsp.push_back(r);
  endtask

  task automatic issue(input int idx, input bit wr, input logic [9:0] ch,
                       input logic [5:0] ofs, input logic [15:0] wd);
    bit got;
    @(posedge clk); #1;
    req_write[idx] = wr;
    req_chan[idx*CH_W +: CH_W] = ch;
    req_offset[idx*6 +: 6] = ofs;
    req_wdata[idx*16 +: 16] = wd;
    req_valid[idx] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (req_ready[idx]) got = 1'b1;
    end
    chk("grant_wait", 32'(got), 32'h1);
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_rsps(input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < 400 && seen < n; i++) begin
      @(negedge clk);
      if (|rsp_valid) seen++;
    end
    chk("rsp_wait", 32'(seen), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- Directed sequence ----------------
  initial begin
    bit found;
    rst = 1'b1;
    req_valid = '0; req_write = '0; req_chan = '0; req_offset = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
    chk("rst_rsp_error", 32'(rsp_error), 32'h0);
    chk("rst_address", 32'(address), 32'h0);
    chk("rst_read", 32'(read), 32'h0);
    chk("rst_write", 32'(write), 32'h0);
    chk("rst_writedata", writedata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: basic write from requester 0
    exp_req(0, 1'b1, 10'd3, 6'h05, 16'h001F, 1, 1'b0, 1'b0, 16'h0, 0);
    issue(0, 1'b1, 10'd3, 6'h05, 16'h001F);
    wait_rsps(1);

    // 2: read from requester 1, busy for 3 polls
    ctrl_base = ctrl_reads; busy_polls = 3; data_val = 32'h0000_0ABC;
    exp_req(1, 1'b0, 10'd1, 6'h02, 16'h0, 4, 1'b0, 1'b0, 16'h0ABC, 0);
    issue(1, 1'b0, 10'd1, 6'h02, 16'h0);
    wait_rsps(1);
    busy_polls = 0;

    // 3: waitrequest held 5 cycles on the offset write
    wait_base = wait_cycles; wait_addr = A_OFS; wait_len = 5;
    exp_req(1, 1'b1, 10'h3FF, 6'h3F, 16'hBEEF, 1, 1'b0, 1'b0, 16'h0, 5);
    issue(1, 1'b1, 10'h3FF, 6'h3F, 16'hBEEF);
    wait_rsps(1);
    wait_len = 0;

    // 4: both requesters held valid, grants must alternate
    data_val = 32'h0000_5A5A;
    for (int i = 0; i < 2; i++) begin
      exp_req(0, 1'b1, 10'd5, 6'h11, 16'h1234, 1, 1'b0, 1'b0, 16'h0, 0);
      exp_req(1, 1'b0, 10'd7, 6'h22, 16'h0, 1, 1'b0, 1'b0, 16'h5A5A, 0);
    end
    @(posedge clk); #1;
    req_write = 2'b01;
    req_chan = {10'd7, 10'd5};
    req_offset = {6'h22, 6'h11};
    req_wdata = {16'h0, 16'h1234};
    req_valid = 2'b11;
    wait_rsps(4);
    @(posedge clk); #1;
    req_valid = 2'b00;

    // 5: busy stuck, timeout after 4 polls
    ctrl_base = ctrl_reads; busy_polls = 1000;
    exp_req(0, 1'b0, 10'd2, 6'h03, 16'h0, TOUT, 1'b1, 1'b0, 16'h0, 0);
    issue(0, 1'b0, 10'd2, 6'h03, 16'h0);
    wait_rsps(1);
    busy_polls = 0;

    // 6: status error bit on a read
    status_val = 32'h0000_0200; data_val = 32'h0000_7777;
    exp_req(1, 1'b0, 10'd9, 6'h0A, 16'h0, 1, 1'b0, 1'b1, 16'h7777, 0);
    issue(1, 1'b0, 10'd9, 6'h0A, 16'h0);
    wait_rsps(1);
    status_val = 32'h0;

    // 7: reset during POLL abandons the op
    acc_chk_en = 1'b0;
    ctrl_base = ctrl_reads; busy_polls = 1000;
    exp_req(0, 1'b0, 10'd4, 6'h04, 16'h0, 1, 1'b0, 1'b0, 16'h0, 0);
    issue(0, 1'b0, 10'd4, 6'h04, 16'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (read && address == A_CTRL) found = 1'b1;
    end
    chk("reach_poll", 32'(found), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_read", 32'(read), 32'h0);
    chk("midrst_write", 32'(write), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    exp_rsp.delete();
    exp_acc.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    busy_polls = 0;
    repeat (3) @(posedge clk);
    #1;
    acc_chk_en = 1'b1;
    exp_req(1, 1'b1, 10'h2A, 6'h15, 16'hCAFE, 1, 1'b0, 1'b0, 16'h0, 0);
    issue(1, 1'b1, 10'h2A, 6'h15, 16'hCAFE);
    wait_rsps(1);

    repeat (3) @(negedge clk);
    chk("exp_acc_drained", 32'(exp_acc.size()), 32'h0);
    chk("exp_rsp_drained", 32'(exp_rsp.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
